wb_sram_arbiter: RTL



---
 rtl/j1_wb_pkg.sv | 21 ++
 rtl/sram_rr_arbiter.sv | 28 ++
 rtl/wb_sram_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/j1_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j1_wb_pkg
// Brief    : Shared types and sizes for the Wishbone-to-async-SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package j1_wb_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int WAIT_CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } sram_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rr_arbiter
// Brief    : Two-way round-robin grant, one-hot, valid only while advance=1.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rr_arbiter (
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the master that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_sram_arbiter
// Brief    : Two Wishbone classic masters sharing one 256Kx16 async SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module wb_sram_arbiter
  import j1_wb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,

  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [SRAM_AW-1:0] m0_adr_i,
  input  logic [1:0]         m0_sel_i,
  input  logic [SRAM_DW-1:0] m0_dat_i,
  output logic [SRAM_DW-1:0] m0_dat_o,
  output logic               m0_ack_o,

  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [SRAM_AW-1:0] m1_adr_i,
  input  logic [1:0]         m1_sel_i,
  input  logic [SRAM_DW-1:0] m1_dat_i,
  output logic [SRAM_DW-1:0] m1_dat_o,
  output logic               m1_ack_o,

  output logic [SRAM_AW-1:0] sram_a_o,
  inout  wire  [SRAM_DW-1:0] sram_d_io,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic               sram_lb_n_o,
  output logic               sram_ub_n_o
);

  localparam logic [WAIT_CW-1:0] c_wait_load = WAIT_CW'(WAIT_CYCLES - 1);

  sram_state_t        r_state;
  sram_state_t        w_state_nxt;
  logic               r_gnt;
  logic               r_last_grant;
  logic [WAIT_CW-1:0] r_wait_cnt;
  logic               r_we;
  logic [1:0]         r_sel;
  logic [SRAM_DW-1:0] r_wdat;
  logic [SRAM_AW-1:0] r_adr;
  logic               r_drive;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_lb_n;
  logic               r_ub_n;
  logic [SRAM_DW-1:0] r_m0_dat;
  logic [SRAM_DW-1:0] r_m1_dat;

  logic [1:0]         w_req;
  logic [1:0]         w_grant;
  logic               w_start;
  logic               w_last_access;
  logic               w_we_nxt;
  logic [1:0]         w_sel_nxt;
  logic               w_busy_nxt;
  logic               w_strobe_nxt;

  assign w_req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  sram_rr_arbiter u_arb (
    .req        (w_req),
    .advance    (r_state == IDLE),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign w_start       = |w_grant;
  assign w_last_access = (r_state == ACCESS) && (r_wait_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_last_access) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so the pins switch cleanly on the edge.
  assign w_we_nxt     = w_start ? (w_grant[1] ? m1_we_i  : m0_we_i)  : r_we;
  assign w_sel_nxt    = w_start ? (w_grant[1] ? m1_sel_i : m0_sel_i) : r_sel;
  assign w_busy_nxt   = (w_state_nxt != IDLE);
  assign w_strobe_nxt = (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
      r_we         <= 1'b0;
      r_sel        <= 2'b00;
      r_wdat       <= '0;
      r_adr        <= '0;
      r_drive      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_m0_dat     <= '0;
      r_m1_dat     <= '0;
    end else begin
      if (w_start) begin
        r_gnt        <= w_grant[1];
        r_last_grant <= w_grant[1];
        r_we         <= w_we_nxt;
        r_sel        <= w_sel_nxt;
        r_adr        <= w_grant[1] ? m1_adr_i : m0_adr_i;
        r_wdat       <= w_grant[1] ? m1_dat_i : m0_dat_i;
      end

      if (r_state == SETUP)
        r_wait_cnt <= c_wait_load;
      else if ((r_state == ACCESS) && (r_wait_cnt != '0))
        r_wait_cnt <= r_wait_cnt - WAIT_CW'(1);

      if (w_last_access && !r_we) begin
        if (r_gnt) r_m1_dat <= sram_d_io;
        else       r_m0_dat <= sram_d_io;
      end

      r_ce_n  <= ~w_busy_nxt;
      r_oe_n  <= ~(~w_we_nxt & w_strobe_nxt);
      r_we_n  <= ~(w_we_nxt & (w_state_nxt == ACCESS));
      r_lb_n  <= ~(w_busy_nxt & w_sel_nxt[0]);
      r_ub_n  <= ~(w_busy_nxt & w_sel_nxt[1]);
      r_drive <= w_we_nxt & w_busy_nxt;
    end
  end

  // An owner that dropped cyc mid-access gets no ack; the SRAM cycle still completes.
  assign m0_ack_o = (r_state == DONE) && !r_gnt && m0_cyc_i;
  assign m1_ack_o = (r_state == DONE) &&  r_gnt && m1_cyc_i;
  assign m0_dat_o = r_m0_dat;
  assign m1_dat_o = r_m1_dat;

  assign sram_a_o    = r_adr;
  assign sram_d_io   = r_drive ? r_wdat : {SRAM_DW{1'bz}};
  assign sram_ce_n_o = r_ce_n;
  assign sram_oe_n_o = r_oe_n;
  assign sram_we_n_o = r_we_n;
  assign sram_lb_n_o = r_lb_n;
  assign sram_ub_n_o = r_ub_n;

endmodule
`default_nettype wire
